// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-command bundle shared by the IF port, the DM port and the memory.
// master = requesters + memory (environment side), slave = the arbiter.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        owner;
    logic [15:0] conflict_cnt;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, owner, conflict_cnt
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data ports; valid at T+2+MEM_LAT.
// Requesters hold req until their valid pulse; one transaction per MEM_LAT+3 cycles, no queueing.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        grant_dm;

    // owner_q doubles as last_owner: both change only on a grant, to the same value.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        if_rdata_d     = if_rdata_q;
        dm_rdata_d     = dm_rdata_q;
        conflict_cnt_d = conflict_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        grant_dm       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req && bus.dm_req && (conflict_cnt_q != 16'hFFFF)) begin
                    conflict_cnt_d = conflict_cnt_q + 16'd1;
                end
                if (bus.if_req || bus.dm_req) begin
                    grant_dm = bus.dm_req && (!bus.if_req || !owner_q);
                    owner_d  = grant_dm;
                    we_d     = grant_dm && bus.dm_we;
                    addr_d   = grant_dm ? bus.dm_addr  : bus.if_addr;
                    wdata_d  = grant_dm ? bus.dm_wdata : 32'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = 3'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d = RESP;
                    if (!owner_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            if_rdata_q     <= 32'd0;
            dm_rdata_q     <= 32'd0;
            conflict_cnt_q <= 16'd0;
            wait_cnt_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign bus.mem_en       = (state_q == ISSUE);
    assign bus.mem_we       = (state_q == ISSUE) && we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.if_valid     = (state_q == RESP) && !owner_q;
    assign bus.dm_valid     = (state_q == RESP) && owner_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.dm_rdata     = dm_rdata_q;
    assign bus.owner        = owner_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule
